// File: rtl/instruction_decoder_pkg.sv
// Shared opcode classes, field positions, ALU codes and register names for the
// instruction decoder and its neighbours.
package instruction_decoder_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned NUM_REG = 8;

  // Instruction classes, recognised from the leading prefix bits
  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,  // 0ddd_iiii
    OP_MOVE = 3'd1,  // 10dd_dsss
    OP_ALU  = 3'd2,  // 110f_ffxy
    OP_JMP  = 3'd3,  // 1110_aaaa
    OP_JNZ  = 3'd4   // 1111_aaaa
  } opclass_e;

  // Field bit positions (LSB of each field)
  localparam int unsigned LOAD_DST_LSB = 4;  // ddd in [6:4]
  localparam int unsigned LOAD_IMM_LSB = 0;  // iiii in [3:0]
  localparam int unsigned MOVE_DST_LSB = 3;  // ddd in [5:3]
  localparam int unsigned MOVE_SRC_LSB = 0;  // sss in [2:0]
  localparam int unsigned ALU_FN_LSB   = 2;  // fff in [4:2]
  localparam int unsigned ALU_X_BIT    = 1;
  localparam int unsigned ALU_Y_BIT    = 0;
  localparam int unsigned JMP_ADDR_LSB = 0;  // aaaa in [3:0]

  // ALU function codes as interpreted by the datapath
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // Destination register indices
  localparam logic [2:0] REG_X0 = 3'd0;
  localparam logic [2:0] REG_X1 = 3'd1;
  localparam logic [2:0] REG_Y0 = 3'd2;
  localparam logic [2:0] REG_Y1 = 3'd3;
  localparam logic [2:0] REG_R0 = 3'd4;
  localparam logic [2:0] REG_R1 = 3'd5;
  localparam logic [2:0] REG_O  = 3'd6;
  localparam logic [2:0] REG_R  = 3'd7;  // ALU result register

  // Classify an instruction word by its prefix
  function automatic opclass_e op_class(input logic [INSTR_W-1:0] w);
    opclass_e c;
    if (!w[7])      c = OP_LOAD;
    else if (!w[6]) c = OP_MOVE;
    else if (!w[5]) c = OP_ALU;
    else if (!w[4]) c = OP_JMP;
    else            c = OP_JNZ;
    return c;
  endfunction

endpackage

// File: rtl/instruction_decoder_zero_flag_reg.sv
// Zero flag register: captures the ALU zero indication when loaded, holds otherwise.
module zero_flag_reg (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic d_i,
  output logic q_o
);

  logic flag_q;

  // Sync reset clears the flag; load captures d_i, otherwise hold
  always_ff @(posedge clk_i) begin
    if (rst_i)       flag_q <= 1'b0;
    else if (load_i) flag_q <= d_i;
  end

  assign q_o = flag_q;

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: combinational decode of the program memory word into
// sequencer jump controls and datapath strobes, plus the zero flag and a
// debug instruction register.
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int IW   = 8,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            sync_reset,
  input  logic [IW-1:0]   pm_data,
  input  logic            alu_zero,
  output logic            jmp,
  output logic            jmp_nz,
  output logic [3:0]      jmp_addr,
  output logic            dont_jmp,
  output logic [NREG-1:0] reg_en,
  output logic [2:0]      src_sel,
  output logic            imm_sel,
  output logic [3:0]      imm,
  output logic [2:0]      alu_func,
  output logic            alu_xsel,
  output logic            alu_ysel,
  output logic [IW-1:0]   from_ID
);

  typedef enum logic {ST_RST, ST_RUN} state_e;

  state_e          state_q;
  logic [IW-1:0]   ir_q;

  logic            jmp_d;
  logic            jmp_nz_d;
  logic [3:0]      jmp_addr_d;
  logic [NREG-1:0] reg_en_d;
  logic [2:0]      src_sel_d;
  logic            imm_sel_d;
  logic [3:0]      imm_d;
  logic [2:0]      alu_func_d;
  logic            alu_xsel_d;
  logic            alu_ysel_d;
  logic            flag_load_d;

  logic [2:0]      load_dst;
  logic [2:0]      move_dst;
  logic [2:0]      move_src;

  assign load_dst = pm_data[LOAD_DST_LSB +: 3];
  assign move_dst = pm_data[MOVE_DST_LSB +: 3];
  assign move_src = pm_data[MOVE_SRC_LSB +: 3];

  // Decode pm_data; everything stays zero while reset is asserted
  always_comb begin
    jmp_d       = 1'b0;
    jmp_nz_d    = 1'b0;
    jmp_addr_d  = '0;
    reg_en_d    = '0;
    src_sel_d   = '0;
    imm_sel_d   = 1'b0;
    imm_d       = '0;
    alu_func_d  = '0;
    alu_xsel_d  = 1'b0;
    alu_ysel_d  = 1'b0;
    flag_load_d = 1'b0;
    if (!sync_reset) begin
      unique case (op_class(pm_data))
        OP_LOAD: begin
          reg_en_d[load_dst] = 1'b1;
          imm_sel_d          = 1'b1;
          imm_d              = pm_data[LOAD_IMM_LSB +: 4];
        end
        OP_MOVE: begin
          src_sel_d = move_src;
          // Moving a register onto itself is the NOP encoding
          if (move_dst != move_src) reg_en_d[move_dst] = 1'b1;
        end
        OP_ALU: begin
          alu_func_d      = pm_data[ALU_FN_LSB +: 3];
          alu_xsel_d      = pm_data[ALU_X_BIT];
          alu_ysel_d      = pm_data[ALU_Y_BIT];
          reg_en_d[REG_R] = 1'b1;
          flag_load_d     = 1'b1;
        end
        OP_JMP: begin
          jmp_d      = 1'b1;
          jmp_addr_d = pm_data[JMP_ADDR_LSB +: 4];
        end
        OP_JNZ: begin
          jmp_nz_d   = 1'b1;
          jmp_addr_d = pm_data[JMP_ADDR_LSB +: 4];
        end
        default: ;
      endcase
    end
  end

  assign jmp      = jmp_d;
  assign jmp_nz   = jmp_nz_d;
  assign jmp_addr = jmp_addr_d;
  assign reg_en   = reg_en_d;
  assign src_sel  = src_sel_d;
  assign imm_sel  = imm_sel_d;
  assign imm      = imm_d;
  assign alu_func = alu_func_d;
  assign alu_xsel = alu_xsel_d;
  assign alu_ysel = alu_ysel_d;

  // Reset/run tracking and instruction register capture
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= ST_RST;
      ir_q    <= '0;
    end else begin
      state_q <= ST_RUN;
      ir_q    <= pm_data;
    end
  end

  assign from_ID = ir_q;

  // Once running, the two jump requests must be mutually exclusive
  always_ff @(posedge clk) begin
    if (state_q == ST_RUN && !sync_reset)
      assert (!(jmp_d && jmp_nz_d));
  end

  zero_flag_reg u_zero_flag (
    .clk_i  (clk),
    .rst_i  (sync_reset),
    .load_i (flag_load_d),
    .d_i    (alu_zero),
    .q_o    (dont_jmp)
  );

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed steps followed by
// random words, compared against a behavioural decode model.
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       jmp, jmp_nz, dont_jmp, imm_sel, alu_xsel, alu_ysel;
  logic [3:0] jmp_addr, imm;
  logic [7:0] reg_en, from_ID;
  logic [2:0] src_sel, alu_func;

  int total = 0;
  int bad   = 0;

  // Model state: flag and instruction register as they stand after each edge
  logic       m_flag;
  logic [7:0] m_ir;

  typedef struct packed {
    logic       jmp, jmp_nz;
    logic [3:0] addr;
    logic [7:0] en;
    logic [2:0] src;
    logic       isel;
    logic [3:0] imm;
    logic [2:0] fn;
    logic       x, y;
  } exp_t;

  instruction_decoder #(.IW(8), .NREG(8)) dut (
    .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data), .alu_zero(alu_zero),
    .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
    .reg_en(reg_en), .src_sel(src_sel), .imm_sel(imm_sel), .imm(imm),
    .alu_func(alu_func), .alu_xsel(alu_xsel), .alu_ysel(alu_ysel), .from_ID(from_ID)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic rst, input logic [7:0] w);
    exp_t e;
    int unsigned v, d, s;
    e = '0;
    v = w;
    if (!rst) begin
      if (v < 128) begin
        e.en   = 8'(1 << ((v / 16) % 8));
        e.isel = 1'b1;
        e.imm  = 4'(v % 16);
      end else if (v < 192) begin
        d = (v / 8) % 8;
        s = v % 8;
        e.src = 3'(s);
        e.en  = (d == s) ? 8'h00 : 8'(1 << d);
      end else if (v < 224) begin
        e.fn = 3'((v / 4) % 8);
        e.x  = 1'((v / 2) % 2);
        e.y  = 1'(v % 2);
        e.en = 8'h80;
      end else if (v < 240) begin
        e.jmp  = 1'b1;
        e.addr = 4'(v % 16);
      end else begin
        e.jmp_nz = 1'b1;
        e.addr   = 4'(v % 16);
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one word for one cycle, check all outputs mid-cycle, then advance the model
  task automatic step(input logic rst, input logic [7:0] w, input logic z);
    exp_t e;
    sync_reset = rst;
    pm_data    = w;
    alu_zero   = z;
    #2;
    e = model(rst, w);
    chk("jmp",      {7'd0, jmp},      {7'd0, e.jmp});
    chk("jmp_nz",   {7'd0, jmp_nz},   {7'd0, e.jmp_nz});
    chk("jmp_addr", {4'd0, jmp_addr}, {4'd0, e.addr});
    chk("reg_en",   reg_en,           e.en);
    chk("src_sel",  {5'd0, src_sel},  {5'd0, e.src});
    chk("imm_sel",  {7'd0, imm_sel},  {7'd0, e.isel});
    chk("imm",      {4'd0, imm},      {4'd0, e.imm});
    chk("alu_func", {5'd0, alu_func}, {5'd0, e.fn});
    chk("alu_xsel", {7'd0, alu_xsel}, {7'd0, e.x});
    chk("alu_ysel", {7'd0, alu_ysel}, {7'd0, e.y});
    chk("dont_jmp", {7'd0, dont_jmp}, {7'd0, m_flag});
    chk("from_ID",  from_ID,          m_ir);
    @(posedge clk);
    if (rst) begin
      m_flag = 1'b0;
      m_ir   = 8'h00;
    end else begin
      if (w >= 8'hC0 && w < 8'hE0) m_flag = z;
      m_ir = w;
    end
    #1;
  endtask

  initial begin
    sync_reset = 1'b1;
    pm_data    = 8'hE5;
    alu_zero   = 1'b0;
    @(posedge clk);
    #1;
    m_flag = 1'b0;
    m_ir   = 8'h00;

    // Reset held with a JMP word present: nothing decoded, state cleared
    step(1'b1, 8'hE5, 1'b1);
    step(1'b1, 8'hE5, 1'b0);
    step(1'b1, 8'hE5, 1'b1);
    // First word after release decodes immediately
    step(1'b0, 8'hE5, 1'b0);
    // ALU with zero, then JNZ sees the flag set
    step(1'b0, 8'hC4, 1'b1);
    step(1'b0, 8'hF3, 1'b0);
    step(1'b0, 8'hC4, 1'b0);
    step(1'b0, 8'hF3, 1'b1);
    // LOAD and MOVE, including the self-move NOP
    step(1'b0, 8'h3A, 1'b0);
    step(1'b0, 8'h9B, 1'b0);
    step(1'b0, 8'h9A, 1'b1);
    // Flag holds across non-ALU instructions while alu_zero toggles
    step(1'b0, 8'hDF, 1'b1);
    step(1'b0, 8'h9A, 1'b0);
    step(1'b0, 8'h7F, 1'b0);
    step(1'b0, 8'hA8, 1'b0);
    step(1'b0, 8'hF0, 1'b0);
    // Reset during an ALU word with alu_zero=1 aborts the flag update
    step(1'b1, 8'hC4, 1'b1);
    step(1'b0, 8'hF3, 1'b1);

    // Random words, occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(15) == 0) ? 1'b1 : 1'b0, 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
